// File: rtl/present_pkg.sv
// Shared PRESENT key-schedule definitions; KEY_W is 128 when KEY_128_EN is defined, else 80.
package present_pkg;

`ifdef KEY_128_EN
  localparam int unsigned KEY_W = 128;
`else
  localparam int unsigned KEY_W = 80;
`endif

  localparam int unsigned RK_W   = 64;
  localparam int unsigned NUM_RK = 32;

  localparam logic [4:0] LAST_IDX = 5'(NUM_RK - 1);

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SBOX[x];
  endfunction

endpackage

// File: rtl/present_key_update.sv
// One PRESENT key-schedule step: rotate left 61, S-box the top nibble(s), XOR the round counter.
// KEY_128_EN selects the 128-bit variant.
module present_key_update
  import present_pkg::*;
(
  input  logic [KEY_W-1:0] key_i,
  input  logic [4:0]       round_i,
  output logic [KEY_W-1:0] key_o
);

  logic [KEY_W-1:0] rot;

  always_comb begin
    rot   = {key_i[KEY_W-62:0], key_i[KEY_W-1:KEY_W-61]};
    key_o = rot;
    key_o[KEY_W-1 -: 4] = sbox(rot[KEY_W-1 -: 4]);
`ifdef KEY_128_EN
    key_o[KEY_W-5 -: 4] = sbox(rot[KEY_W-5 -: 4]);
    key_o[66:62]        = rot[66:62] ^ round_i;
`else
    key_o[19:15]        = rot[19:15] ^ round_i;
`endif
  end

endmodule

// File: rtl/present_key_sched_ctrl.sv
// PRESENT key-schedule sequencer: accepts a key, streams K1..K32 with backpressure, then flushes.
// Key width follows KEY_128_EN (see present_pkg).
module present_key_sched_ctrl
  import present_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key_in,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic             abort,
  output logic [RK_W-1:0]  rk_data,
  output logic [4:0]       rk_idx,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic             rk_last,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d, key_upd;
  logic [4:0]       idx_q, idx_d;
  logic             ready_q, ready_d;
  logic [4:0]       round_nxt;

  assign round_nxt = idx_q + 5'd1;

  present_key_update u_key_update (
    .key_i   (key_q),
    .round_i (round_nxt),
    .key_o   (key_upd)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (key_valid && ready_q) begin
          key_d   = key_in;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (rk_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_FLUSH;
          end else begin
            key_d = key_upd;
            idx_d = round_nxt;
          end
        end
      end
      ST_FLUSH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // abort overrides both handshakes; every FLUSH entry scrubs the key and index
    if (abort) state_d = ST_FLUSH;
    if (state_d == ST_FLUSH) begin
      key_d = '0;
      idx_d = '0;
    end
    // registered ready keeps key_ready low through reset and decoupled from key_valid
    ready_d = (state_d == ST_IDLE);
  end

  assign key_ready = ready_q;
  assign rk_valid  = (state_q == ST_RUN);
  assign rk_last   = (state_q == ST_RUN) && (idx_q == LAST_IDX);
  assign busy      = (state_q != ST_IDLE);
  assign rk_data   = key_q[KEY_W-1 -: RK_W];
  assign rk_idx    = idx_q;

endmodule

// File: tb/tb_present_key_sched_ctrl.sv
// Self-checking bench for present_key_sched_ctrl against an arithmetic key-schedule model.
module tb_present_key_sched_ctrl;

  localparam int KW = present_pkg::KEY_W;

  logic          clk = 1'b0;
  logic          rst_n, key_valid, abort, rk_ready;
  logic [KW-1:0] key_in;
  logic          key_ready, rk_valid, rk_last, busy;
  logic [63:0]   rk_data;
  logic [4:0]    rk_idx;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [3:0]  sb [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                           4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  logic [63:0] exp_rk [32];
  logic [63:0] cap_rk [32];

  always #5 clk = ~clk;

  present_key_sched_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_in    (key_in),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .abort     (abort),
    .rk_data   (rk_data),
    .rk_idx    (rk_idx),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk_last   (rk_last),
    .busy      (busy)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [KW-1:0] rand_key();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    return t[KW-1:0];
  endfunction

  // Round keys from the algorithm definition: K(r+1) = rotl61, S-box top nibble(s), XOR counter.
  task automatic model(input logic [KW-1:0] key);
    logic [KW-1:0] k;
    int            xor_pos;
    k       = key;
    xor_pos = (KW == 128) ? 62 : 15;
    for (int r = 0; r < 32; r++) begin
      exp_rk[r] = k[KW-1 -: 64];
      k = (k << 61) | (k >> (KW - 61));
      k[KW-1 -: 4] = sb[k[KW-1 -: 4]];
      if (KW == 128) k[KW-5 -: 4] = sb[k[KW-5 -: 4]];
      k = k ^ (KW'(r + 1) << xor_pos);
    end
  endtask

  task automatic send_key(input logic [KW-1:0] key, output int waited);
    waited = 0;
    while (key_ready !== 1'b1 && waited < 64) begin
      step();
      waited++;
    end
    chk("key_ready before send", 64'(key_ready), 64'd1);
    key_in    = key;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    chk("busy after accept", 64'(busy), 64'd1);
    chk("key_ready low in RUN", 64'(key_ready), 64'd0);
  endtask

  task automatic run_key(input logic [KW-1:0] key, input bit rnd, output int waited);
    int          got, cyc;
    bit          hs, stall;
    logic [63:0] pd;
    logic [4:0]  pi;
    model(key);
    send_key(key, waited);
    got = 0; cyc = 0; stall = 1'b0; pd = '0; pi = '0;
    while (got < 32 && cyc < 4000) begin
      chk("rk_valid in RUN", 64'(rk_valid), 64'd1);
      chk("rk_idx", 64'(rk_idx), 64'(got));
      chk("rk_data", rk_data, exp_rk[got]);
      chk("rk_last", 64'(rk_last), 64'(got == 31));
      if (stall) begin
        chk("stalled rk_data stable", rk_data, pd);
        chk("stalled rk_idx stable", 64'(rk_idx), 64'(pi));
      end
      cap_rk[got] = rk_data;
      pd          = rk_data;
      pi          = rk_idx;
      rk_ready    = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      key_valid   = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      key_in      = rand_key();
      hs          = rk_ready;
      stall       = !rk_ready;
      step();
      cyc++;
      if (hs) got++;
    end
    key_valid = 1'b0;
    rk_ready  = 1'b0;
    chk("round keys delivered", 64'(got), 64'd32);
    chk("FLUSH rk_valid", 64'(rk_valid), 64'd0);
    chk("FLUSH rk_last", 64'(rk_last), 64'd0);
    chk("FLUSH key_ready", 64'(key_ready), 64'd0);
    chk("FLUSH rk_data scrubbed", rk_data, 64'd0);
    step();
    chk("key_ready after FLUSH", 64'(key_ready), 64'd1);
    chk("rk_valid after FLUSH", 64'(rk_valid), 64'd0);
  endtask

  initial begin
    int            w, n;
    logic [KW-1:0] k;

    rst_n = 1'b0; key_valid = 1'b0; abort = 1'b0; rk_ready = 1'b0; key_in = '0;
    step(); step();
    chk("reset rk_valid", 64'(rk_valid), 64'd0);
    chk("reset rk_last", 64'(rk_last), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset key_ready", 64'(key_ready), 64'd0);
    chk("reset rk_idx", 64'(rk_idx), 64'd0);
    chk("reset rk_data", rk_data, 64'd0);
    rst_n = 1'b1;
    step();
    chk("key_ready after reset release", 64'(key_ready), 64'd1);

    // Zero key with known round keys
    run_key('0, 1'b0, w);
    chk("K1 zero key", cap_rk[0], 64'h0000000000000000);
`ifdef KEY_128_EN
    chk("K2 zero key", cap_rk[1], 64'hCC00000000000000);
`else
    chk("K2 zero key", cap_rk[1], 64'hC000000000000000);
    chk("K3 zero key", cap_rk[2], 64'h5000180000000001);
`endif

    // Random keys with random backpressure and ignored mid-RUN key_valid
    for (int i = 0; i < 3; i++) run_key(rand_key(), 1'b1, w);

    // Back-to-back: next key taken the cycle key_ready rises
    run_key(rand_key(), 1'b0, w);
    run_key(rand_key(), 1'b0, w);
    chk("back-to-back no wait", 64'(w), 64'd0);

    // Abort at idx 10 together with rk_ready
    k = rand_key();
    model(k);
    send_key(k, w);
    rk_ready = 1'b1; n = 0;
    while (rk_idx != 5'd10 && n < 64) begin step(); n++; end
    chk("reached idx 10", 64'(rk_idx), 64'd10);
    chk("rk_data at idx 10", rk_data, exp_rk[10]);
    abort = 1'b1;
    step();
    abort = 1'b0; rk_ready = 1'b0;
    chk("abort rk_valid", 64'(rk_valid), 64'd0);
    chk("abort key_ready", 64'(key_ready), 64'd0);
    chk("abort rk_data scrubbed", rk_data, 64'd0);
    step();
    chk("key_ready after abort", 64'(key_ready), 64'd1);
    run_key(rand_key(), 1'b0, w);
    chk("restart after abort no wait", 64'(w), 64'd0);

    // Reset mid-RUN at idx 5
    k = rand_key();
    model(k);
    send_key(k, w);
    rk_ready = 1'b1; n = 0;
    while (rk_idx != 5'd5 && n < 64) begin step(); n++; end
    chk("reached idx 5", 64'(rk_idx), 64'd5);
    rst_n = 1'b0;
    step();
    rk_ready = 1'b0;
    chk("mid-run reset rk_valid", 64'(rk_valid), 64'd0);
    chk("mid-run reset busy", 64'(busy), 64'd0);
    chk("mid-run reset rk_idx", 64'(rk_idx), 64'd0);
    chk("mid-run reset key_ready", 64'(key_ready), 64'd0);
    step();
    chk("held reset key_ready", 64'(key_ready), 64'd0);
    rst_n = 1'b1;
    step();
    chk("key_ready after mid-run reset", 64'(key_ready), 64'd1);
    chk("no rk_valid after reset", 64'(rk_valid), 64'd0);
    run_key(rand_key(), 1'b1, w);

    // Abort in IDLE beats a simultaneous key handshake
    key_in = rand_key(); key_valid = 1'b1; abort = 1'b1;
    step();
    key_valid = 1'b0; abort = 1'b0;
    chk("abort vs key rk_valid", 64'(rk_valid), 64'd0);
    chk("abort vs key key_ready", 64'(key_ready), 64'd0);
    chk("abort vs key rk_data", rk_data, 64'd0);
    step();
    chk("abort vs key back to idle", 64'(key_ready), 64'd1);
    chk("abort vs key busy", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/present_key_sched_ctrl.md
# present_key_sched_ctrl

Sequencing controller for the PRESENT key schedule. It accepts a cipher key through a valid/ready handshake and iterates a single key-update stage once per accepted round key. It streams the 32 round keys K1..K32, with backpressure, to the round datapath. It sits between the key source and the encryption round pipeline, and owns the round counter and the key register.

## Interface
- Parameters
  - NUM_RK, 32: round keys emitted per key; fixed by the algorithm and not overridable.
  - RK_W, 64: round-key width.
- Ports
  - clk  in  1: single clock; all state is on its rising edge.
  - rst_n  in  1: reset, synchronous and active-low.
  - key_in  in  KEY_W: cipher key. KEY_W is 80, or 128 with KEY_128_EN.
  - key_valid  in  1: key_in is valid.
  - key_ready  out  1: controller is idle and can take a key.
  - abort  in  1: synchronously discards the current schedule.
  - rk_data  out  64: current round key, equal to key_reg[KEY_W-1:KEY_W-64].
  - rk_idx  out  5: round-key index 0..31, where 0 is K1.
  - rk_valid  out  1: rk_data and rk_idx are valid.
  - rk_ready  in  1: consumer accepts the round key.
  - rk_last  out  1: rk_valid is high and rk_idx is 31.
  - busy  out  1: state is not IDLE.

## Operation
- States are IDLE, RUN and FLUSH.
- IDLE
  - key_ready is 1.
  - On key_valid & key_ready: key_reg <= key_in, rk_idx <= 0, go to RUN.
- RUN
  - rk_valid is 1.
  - On rk_valid & rk_ready with rk_idx < 31: key_reg <= update(key_reg, rk_idx+1), rk_idx <= rk_idx+1.
  - On the handshake at rk_idx 31: go to FLUSH.
- FLUSH
  - Lasts one cycle; all outputs are deasserted.
  - key_reg is cleared to 0 so key material does not persist.
  - Next state is IDLE.
- update(k, i) for KEY_W = 80:
  - rotate k left by 61;
  - S-box bits [79:76];
  - bits [19:15] ^= i[4:0].
- update(k, i) for KEY_W = 128:
  - rotate k left by 61;
  - S-box bits [127:124] and [123:120];
  - bits [66:62] ^= i[4:0].
- The round counter i runs 1..31 and never wraps. rk_idx saturates at 31.
- abort, in any state, forces FLUSH on the next edge. Abort takes priority over a simultaneous rk handshake or key handshake.
- key_valid outside IDLE is ignored, and key_in is not sampled.
- rk_data, rk_idx and rk_last must stay stable while rk_valid & !rk_ready.

## Timing
- Reset (rst_n low at an edge):
  - state = IDLE, key_reg = 0, rk_idx = 0.
  - rk_valid, rk_last and busy are 0.
  - key_ready is 0 during reset and goes to 1 on the first edge after rst_n rises.
- Reset applied mid-RUN abandons the schedule with no further rk_valid.
- Latency:
  - key handshake at edge N gives rk_valid = 1 with K1 after edge N.
  - with rk_ready held high, one round key per cycle; K32 appears 31 cycles after K1.
- After the K32 handshake: one FLUSH cycle, then key_ready = 1. The minimum key-to-key period is 34 cycles.
- All outputs are registered or decoded from registered state only. There is no combinational path from rk_ready or key_valid to any output.

## Configuration
- KEY_128_EN defined:
  - KEY_W = 128;
  - two S-box lookups per update;
  - counter XOR at [66:62].
- KEY_128_EN undefined:
  - KEY_W = 80;
  - one S-box lookup;
  - counter XOR at [19:15].
- Ports other than key_in and all timing are identical in both builds.

## Structure
- A shared package present_pkg holds:
  - KEY_W, derived from KEY_128_EN;
  - RK_W = 64 and NUM_RK = 32;
  - the 16-entry S-box constant array {C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2};
  - the state enum typedef.
- Sub-module present_key_update is purely combinational, with ports (key_i, round_i[4:0], key_o). It is the update() function and is instantiated once.
- The controller holds the FSM, key_reg and rk_idx.

## Test plan
- 80-bit build, key 0, rk_ready held 1: K1 = 0x0000000000000000, K2 = 0xC000000000000000, K3 = 0x5000180000000001. Exactly 32 rk_valid cycles, with rk_last only on idx 31.
- 128-bit build, key 0: K1 = 0x0000000000000000, K2 = 0xCC00000000000000.
- Backpressure: rk_ready toggles randomly.
  - rk_data and rk_idx stay stable while stalled.
  - The sequence matches the unstalled run.
  - key_valid asserted mid-RUN is ignored.
- abort during idx 10 together with rk_ready = 1: the next cycle is FLUSH with rk_valid = 0, then key_ready = 1. A new key restarts at idx 0 with the new K1.
- Reset mid-RUN at idx 5: rk_valid = 0 at the next edge and key_ready = 1 after rst_n rises.
- Back-to-back keys: a second key is accepted exactly 2 cycles after the K32 handshake, and its K1 is correct.
